// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Synchronises an asynchronous switch word, debounces it as a
//               whole, and presents each new stable value once over a
//               valid/ready handshake together with the changed-bit mask.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
  parameter int DATA_WIDTH      = 16,
  parameter int SYNC_DEPTH      = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_async_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [DATA_WIDTH-1:0] o_toggled,
  output logic                  o_valid,
  input  logic                  i_ready
);

  // Terminal value of the stability counter; it never counts past this.
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [SYNC_DEPTH-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                w_syncd;
  logic [DATA_WIDTH-1:0]                r_cand;
  logic [DATA_WIDTH-1:0]                w_cand_nxt;
  logic [CNT_WIDTH-1:0]                 r_cnt;
  logic [CNT_WIDTH-1:0]                 w_cnt_nxt;
  logic [DATA_WIDTH-1:0]                r_data;
  logic [DATA_WIDTH-1:0]                w_data_nxt;
  logic [DATA_WIDTH-1:0]                r_toggled;
  logic [DATA_WIDTH-1:0]                w_toggled_nxt;

  // Multi-flop synchroniser chain; every switch bit shares the same chain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_async_data;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_syncd = r_sync[SYNC_DEPTH-1];

  // State, candidate word, stability counter and committed outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_toggled <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_toggled <= w_toggled_nxt;
    end
  end

  // Next-state logic: a change restarts the window, a full quiet window
  // commits the word unless it simply returned to the committed value.
  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_toggled_nxt = r_toggled;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_syncd != r_data) begin
          w_cand_nxt  = w_syncd;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_syncd != r_cand) begin
          w_cand_nxt = w_syncd;
          w_cnt_nxt  = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_cand == r_data) begin
            w_state_nxt = IDLE;
          end else begin
            w_data_nxt    = r_cand;
            w_toggled_nxt = r_cand ^ r_data;
            w_state_nxt   = PRESENT;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESENT: begin
        w_cnt_nxt = '0;
        if (i_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_valid   = (r_state == PRESENT);
  assign o_data    = r_data;
  assign o_toggled = r_toggled;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Directed bench for switch_debouncer with a presentation
//               scoreboard (expected word, mask and arrival cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

  logic        clk;
  logic        n_rst;
  logic [15:0] i_async_data;
  logic [15:0] o_data;
  logic [15:0] o_toggled;
  logic        o_valid;
  logic        i_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] d;
    logic [15:0] t;
    int          c;
  } exp_t;

  exp_t sb[$];
  logic prev_valid = 1'b0;

  switch_debouncer #(
    .DATA_WIDTH     (16),
    .SYNC_DEPTH     (2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_async_data(i_async_data),
    .o_data      (o_data),
    .o_toggled   (o_toggled),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: value after the k-th rising edge is k.
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] t, input int c);
    exp_t e;
    e.d = d;
    e.t = t;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: every new presentation pops and checks one entry.
  always @(negedge clk) begin
    if (o_valid === 1'b1 && prev_valid !== 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_valid observed data=%h expected=no_presentation", o_data);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", o_data, e.d);
        check("sb_toggled", o_toggled, e.t);
        check("sb_cycle", cyc, e.c);
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    n_rst        = 1'b0;
    i_async_data = 16'h0000;
    i_ready      = 1'b1;
    tick(2);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_toggled", o_toggled, 0);

    // Idle input: nothing ever presented.
    n_rst = 1'b1;
    tick(100);
    check("idle_valid", o_valid, 0);
    check("idle_data", o_data, 0);

    // Clean step: one-cycle presentation after edge 11.
    i_async_data = 16'h00A5;
    push(16'h00A5, 16'h00A5, cyc + 11);
    tick(10);
    check("step_early", o_valid, 0);
    tick(1);
    check("step_valid", o_valid, 1);
    check("step_data", o_data, 16'h00A5);
    tick(1);
    check("step_one_cycle", o_valid, 0);
    tick(100);

    // Move to 00A4, then bounce bit 0 ending at 1.
    i_async_data = 16'h00A4;
    push(16'h00A4, 16'h0001, cyc + 11);
    tick(20);
    for (int i = 0; i < 10; i++) begin
      i_async_data = 16'h00A4 | 16'(i % 2);
      if (i == 9) push(16'h00A5, 16'h0001, cyc + 11);
      tick(3);
    end
    tick(15);
    check("bounce_data", o_data, 16'h00A5);

    // Short glitch that returns to the committed word.
    i_async_data = 16'hFFFF;
    tick(5);
    i_async_data = 16'h00A5;
    tick(40);
    check("glitch_valid", o_valid, 0);
    check("glitch_data", o_data, 16'h00A5);
    check("glitch_toggled", o_toggled, 16'h0001);

    // Backpressure: held presentation ignores the new input.
    i_async_data = 16'h0000;
    push(16'h0000, 16'h00A5, cyc + 11);
    tick(20);
    i_ready      = 1'b0;
    i_async_data = 16'h00A5;
    push(16'h00A5, 16'h00A5, cyc + 11);
    tick(11);
    check("bp_valid", o_valid, 1);
    i_async_data = 16'h005A;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_data", o_data, 16'h00A5);
    end
    i_ready = 1'b1;
    push(16'h005A, 16'h00FF, cyc + 10);
    tick(1);
    check("bp_drop", o_valid, 0);
    i_ready = 1'b0;
    tick(9);
    check("bp_again_valid", o_valid, 1);
    check("bp_again_data", o_data, 16'h005A);
    tick(5);
    check("bp_again_hold", o_valid, 1);
    i_ready = 1'b1;
    tick(1);
    check("bp_consumed", o_valid, 0);
    tick(20);

    // Asynchronous reset in the middle of a debounce window.
    i_async_data = 16'h0F0F;
    tick(5);
    #2 n_rst = 1'b0;
    #1;
    check("arst_settle_valid", o_valid, 0);
    check("arst_settle_data", o_data, 0);
    check("arst_settle_toggled", o_toggled, 0);
    @(negedge clk);
    i_ready = 1'b0;
    n_rst   = 1'b1;
    push(16'h0F0F, 16'h0F0F, cyc + 11);
    tick(13);
    check("pre_arst_present", o_valid, 1);

    // Asynchronous reset while presenting.
    #2 n_rst = 1'b0;
    #1;
    check("arst_present_valid", o_valid, 0);
    check("arst_present_data", o_data, 0);
    check("arst_present_toggled", o_toggled, 0);
    @(negedge clk);
    i_async_data = 16'h1234;
    i_ready      = 1'b1;
    n_rst        = 1'b1;
    push(16'h1234, 16'h1234, cyc + 11);
    tick(11);
    check("post_rst_valid", o_valid, 1);
    check("post_rst_data", o_data, 16'h1234);
    tick(20);

    // Change lands on syncd exactly while the counter sits at its terminal value.
    i_async_data = 16'h1111;
    tick(8);
    i_async_data = 16'h2222;
    push(16'h2222, 16'h3016, cyc + 11);
    tick(3);
    check("collision_no_commit", o_valid, 0);
    tick(20);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
